// File: rtl/avalon_sdr_xfer.sv
// avalon_sdr_xfer: Avalon-MM bulk transfer engine between a flat element buffer and SDRAM.
// Latency: first command the cycle after start acceptance; end pulse the cycle after the last
//          write accept or the last read data beat.
// Backpressure: a command is held unchanged under waitrequest; reads are throttled so that at
//          most MAX_OUTSTANDING are accepted but unreturned.
// Optional: define SDR_XFER_TIMEOUT_EN to add a no-progress watchdog (TIMEOUT_CYCLES) that
//          aborts a stalled transfer with err set.
module avalon_sdr_xfer #(
  parameter int DATA_W          = 16,
  parameter int ELEM_W          = 32,
  parameter int MAX_NELEMS      = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic                               avm_m0_read,
  output logic                               avm_m0_write,
  output logic [31:0]                        avm_m0_address,
  output logic [DATA_W-1:0]                  avm_m0_writedata,
  output logic [DATA_W/8-1:0]                avm_m0_byteenable,
  input  logic [DATA_W-1:0]                  avm_m0_readdata,
  input  logic                               avm_m0_readdatavalid,
  input  logic                               avm_m0_waitrequest,
  input  logic [31:0]                        xfer_baseaddr,
  input  logic [$clog2(MAX_NELEMS+1)-1:0]    xfer_nelems,
  input  logic [ELEM_W*MAX_NELEMS-1:0]       xfer_writedata,
  output logic [ELEM_W*MAX_NELEMS-1:0]       xfer_readdata,
  input  logic                               xfer_readstart,
  input  logic                               xfer_writestart,
  output logic                               xfer_readend,
  output logic                               xfer_writeend,
  output logic                               xfer_busy,
  output logic                               xfer_err
);

  // Derived sizes: words per element, bytes per word, counter widths.
  localparam int WPE   = ELEM_W / DATA_W;
  localparam int BPW   = DATA_W / 8;
  localparam int NEW   = $clog2(MAX_NELEMS + 1);
  localparam int MAXW  = MAX_NELEMS * WPE;
  localparam int WCW   = $clog2(MAXW + 1);
  localparam int OCW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int BUF_W = ELEM_W * MAX_NELEMS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             op_wr_q, op_wr_d;     // 1: current/last op is a write
  logic [31:0]      base_q, base_d;
  logic [WCW-1:0]   nw_q, nw_d;           // total words of the transfer
  logic [WCW-1:0]   idx_q, idx_d;         // next word to write / next read to issue
  logic [WCW-1:0]   recv_q, recv_d;       // read data beats received
  logic [OCW-1:0]   outst_q, outst_d;     // reads accepted but not yet returned
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [BUF_W-1:0] rdbuf_q, rdbuf_d;

  logic        wr_cmd, rd_cmd, wr_acc, rd_acc, rdv_ok, rdv_dec;
  logic        nelems_bad, timeout;
  logic [31:0] word_addr, wr_off, rd_off;

  // Bus command decode; everything here depends only on flops and the slave's handshake.
  always_comb begin
    wr_cmd     = (state_q == S_WRITE);
    rd_cmd     = (state_q == S_READ) && (idx_q < nw_q) &&
                 (outst_q < OCW'(MAX_OUTSTANDING));
    wr_acc     = wr_cmd && !avm_m0_waitrequest;
    rd_acc     = rd_cmd && !avm_m0_waitrequest;
    // Read data is only meaningful while a read transfer is live; anything else is stale.
    rdv_ok     = avm_m0_readdatavalid && ((state_q == S_READ) || (state_q == S_DRAIN)) &&
                 (recv_q < nw_q);
    rdv_dec    = rdv_ok && (outst_q != '0);
    word_addr  = base_q + 32'(idx_q) * 32'(BPW);
    wr_off     = 32'(idx_q) * 32'(DATA_W);
    rd_off     = 32'(recv_q) * 32'(DATA_W);
    nelems_bad = (xfer_nelems == '0) || (xfer_nelems > NEW'(MAX_NELEMS));
  end

`ifdef SDR_XFER_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] wdog_q, wdog_d;
  logic           xfer_active, progress;

  // Watchdog: counts consecutive no-progress cycles while a transfer is on the bus.
  always_comb begin
    xfer_active = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    progress    = wr_acc || rd_acc || avm_m0_readdatavalid;
    wdog_d      = '0;
    timeout     = 1'b0;
    if (xfer_active && !progress) begin
      if (wdog_q == TCW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  // Watchdog register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Transfer sequencer: start acceptance, word stepping, outstanding tracking, read capture.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    base_d  = base_q;
    nw_d    = nw_q;
    idx_d   = idx_q;
    recv_d  = recv_q;
    outst_d = outst_q;
    busy_d  = busy_q;
    err_d   = err_q;
    rdbuf_d = rdbuf_q;

    // Read data lands in the next buffer slot in arrival order; other slots are untouched.
    if (rdv_ok) begin
      rdbuf_d[rd_off +: DATA_W] = avm_m0_readdata;
      recv_d = recv_q + 1'b1;
    end

    // An accept and a return in the same cycle cancel out.
    if (rd_acc && !rdv_dec) begin
      outst_d = outst_q + 1'b1;
    end else if (!rd_acc && rdv_dec) begin
      outst_d = outst_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (xfer_writestart || xfer_readstart) begin
          op_wr_d = xfer_writestart;           // write wins when both are requested
          base_d  = xfer_baseaddr;
          nw_d    = WCW'(xfer_nelems) * WCW'(WPE);
          idx_d   = '0;
          recv_d  = '0;
          outst_d = '0;
          err_d   = 1'b0;
          if (!xfer_writestart) begin
            rdbuf_d = '0;
          end
          if (nelems_bad) begin
            // Bad count: no bus traffic, report through err and a normal end pulse.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = xfer_writestart ? S_WRITE : S_READ;
          end
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == nw_q - 1'b1) begin
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (rd_acc) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == nw_q - 1'b1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (recv_d == nw_q) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Watchdog abort: responses still in flight are dropped because IDLE ignores them.
    if (timeout) begin
      err_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = S_DONE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      base_q  <= '0;
      nw_q    <= '0;
      idx_q   <= '0;
      recv_q  <= '0;
      outst_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdbuf_q <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      base_q  <= base_d;
      nw_q    <= nw_d;
      idx_q   <= idx_d;
      recv_q  <= recv_d;
      outst_q <= outst_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdbuf_q <= rdbuf_d;
    end
  end

  assign avm_m0_read       = rd_cmd;
  assign avm_m0_write      = wr_cmd;
  assign avm_m0_address    = (rd_cmd || wr_cmd) ? word_addr : '0;
  assign avm_m0_writedata  = wr_cmd ? xfer_writedata[wr_off +: DATA_W] : '0;
  assign avm_m0_byteenable = '1;
  assign xfer_readdata     = rdbuf_q;
  assign xfer_readend      = (state_q == S_DONE) && !op_wr_q;
  assign xfer_writeend     = (state_q == S_DONE) && op_wr_q;
  assign xfer_busy         = busy_q;
  assign xfer_err          = err_q;

endmodule

// File: tb/tb_avalon_sdr_xfer.sv
// Bench for avalon_sdr_xfer: slave model with fixed 4-cycle read latency and a scripted write stall,
// a per-cycle compare process against a queue-based model, and directed scenarios with literal pins.
module tb_avalon_sdr_xfer;
  localparam int DW   = 16;
  localparam int EW   = 32;
  localparam int MN   = 64;
  localparam int MO   = 2;
  localparam int BUFW = EW * MN;

  logic            clk = 1'b0;
  logic            reset;
  logic            avm_m0_read, avm_m0_write;
  logic [31:0]     avm_m0_address;
  logic [DW-1:0]   avm_m0_writedata;
  logic [DW/8-1:0] avm_m0_byteenable;
  logic [DW-1:0]   avm_m0_readdata;
  logic            avm_m0_readdatavalid, avm_m0_waitrequest;
  logic [31:0]     xfer_baseaddr;
  logic [6:0]      xfer_nelems;
  logic [BUFW-1:0] xfer_writedata, xfer_readdata;
  logic            xfer_readstart, xfer_writestart;
  logic            xfer_readend, xfer_writeend, xfer_busy, xfer_err;

  avalon_sdr_xfer #(.DATA_W(DW), .ELEM_W(EW), .MAX_NELEMS(MN), .MAX_OUTSTANDING(MO),
                    .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .reset(reset),
    .avm_m0_read(avm_m0_read), .avm_m0_write(avm_m0_write),
    .avm_m0_address(avm_m0_address), .avm_m0_writedata(avm_m0_writedata),
    .avm_m0_byteenable(avm_m0_byteenable), .avm_m0_readdata(avm_m0_readdata),
    .avm_m0_readdatavalid(avm_m0_readdatavalid), .avm_m0_waitrequest(avm_m0_waitrequest),
    .xfer_baseaddr(xfer_baseaddr), .xfer_nelems(xfer_nelems),
    .xfer_writedata(xfer_writedata), .xfer_readdata(xfer_readdata),
    .xfer_readstart(xfer_readstart), .xfer_writestart(xfer_writestart),
    .xfer_readend(xfer_readend), .xfer_writeend(xfer_writeend),
    .xfer_busy(xfer_busy), .xfer_err(xfer_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- model state ----------------
  typedef struct { logic [31:0] a; logic [15:0] d; } wr_t;
  typedef struct { int due; logic [15:0] d; int tag; } rsp_t;
  wr_t             wq[$];
  logic [31:0]     rq[$];
  rsp_t            rsp[$];
  logic [15:0]     mem [logic [31:0]];
  int              cur_tag = 0, out_cnt = 0, rd_nw = -1, rcv = 0;
  int              exp_wend = -1, exp_rend = -1, wend_cyc = -1, rend_cyc = -1;
  bit              wend_seen = 0, rend_seen = 0;
  int              wr_acc_n = 0, stall_word = -1, stall_left = 0, hold_n = 0, rd_first = -1;
  logic [31:0]     wr_log_a [0:31];
  logic [15:0]     wr_log_d [0:31];
  logic [BUFW-1:0] exp_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_buf(input string name, input logic [BUFW-1:0] act, input logic [BUFW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got[255:0] %h expected[255:0] %h", name, act[255:0], exp[255:0]);
    end
  endtask

  // Unwritten SDRAM locations read back as a fixed function of the address.
  function automatic logic [15:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // ---------------- slave model + per-cycle compare ----------------
  initial begin
    logic        prev_stall;
    logic [31:0] pa;
    logic [15:0] pd;
    wr_t         w;
    rsp_t        r;
    logic [31:0] ra;
    prev_stall = 1'b0;
    pa = '0;
    pd = '0;
    avm_m0_waitrequest   = 1'b0;
    avm_m0_readdatavalid = 1'b0;
    avm_m0_readdata      = '0;
    forever begin
      @(negedge clk);
      chk("writeend_timing", 64'(xfer_writeend), 64'(cyc == exp_wend));
      chk("readend_timing", 64'(xfer_readend), 64'(cyc == exp_rend));
      if (xfer_writeend) begin
        wend_seen = 1;
        wend_cyc  = cyc;
        chk("busy_low_at_writeend", 64'(xfer_busy), 64'd0);
      end
      if (xfer_readend) begin
        rend_seen = 1;
        rend_cyc  = cyc;
        chk("busy_low_at_readend", 64'(xfer_busy), 64'd0);
      end
      if (prev_stall) begin
        chk("hold_write", 64'(avm_m0_write), 64'd1);
        chk("hold_addr", 64'(avm_m0_address), 64'(pa));
        chk("hold_data", 64'(avm_m0_writedata), 64'(pd));
        hold_n++;
      end
      avm_m0_waitrequest = avm_m0_write && (stall_left > 0) && (wr_acc_n == stall_word);
      if (avm_m0_waitrequest) stall_left--;
      prev_stall = avm_m0_waitrequest;
      pa = avm_m0_address;
      pd = avm_m0_writedata;
      if (avm_m0_write || avm_m0_read) chk("busy_during_cmd", 64'(xfer_busy), 64'd1);
      if (avm_m0_write && !avm_m0_waitrequest) begin
        chk("write_expected", 64'(wq.size() > 0), 64'd1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("write_addr", 64'(avm_m0_address), 64'(w.a));
          chk("write_data", 64'(avm_m0_writedata), 64'(w.d));
          mem[avm_m0_address] = avm_m0_writedata;
          if (wr_acc_n < 32) begin
            wr_log_a[wr_acc_n] = avm_m0_address;
            wr_log_d[wr_acc_n] = avm_m0_writedata;
          end
          wr_acc_n++;
          if (wq.size() == 0) exp_wend = cyc + 1;
        end
      end
      if (avm_m0_read) begin
        chk("read_below_outstanding_limit", 64'(out_cnt < MO), 64'd1);
        if (rd_first < 0) rd_first = cyc;
        chk("read_expected", 64'(rq.size() > 0), 64'd1);
        if (rq.size() > 0) begin
          ra = rq.pop_front();
          chk("read_addr", 64'(avm_m0_address), 64'(ra));
          rsp.push_back('{cyc + 4, mem_rd(avm_m0_address), cur_tag});
          out_cnt++;
        end
      end
      avm_m0_readdatavalid = 1'b0;
      avm_m0_readdata      = '0;
      if (rsp.size() > 0 && rsp[0].due == cyc) begin
        r = rsp.pop_front();
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata      = r.d;
        if (r.tag == cur_tag) begin
          out_cnt--;
          rcv++;
          if (rcv == rd_nw) exp_rend = cyc + 1;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_end(input bit is_wr, input string name);
    int n;
    n = 0;
    while (!(is_wr ? wend_seen : rend_seen) && n < 400) begin
      tick();
      n++;
    end
    chk(name, 64'(is_wr ? wend_seen : rend_seen), 64'd1);
  endtask

  task automatic setup_write(input logic [31:0] base, input int n, input logic [31:0] seed);
    xfer_baseaddr  = base;
    xfer_nelems    = 7'(n);
    xfer_writedata = '0;
    for (int i = 0; i < n; i++) xfer_writedata[32*i +: 32] = seed + 32'h0101_0001 * 32'(i);
    for (int k = 0; k < 2*n; k++) wq.push_back('{base + 32'(2*k), xfer_writedata[16*k +: 16]});
    wend_seen = 0;
    wr_acc_n  = 0;
  endtask

  task automatic setup_read(input logic [31:0] base, input int n);
    xfer_baseaddr = base;
    xfer_nelems   = 7'(n);
    exp_rd = '0;
    for (int k = 0; k < 2*n; k++) begin
      exp_rd[16*k +: 16] = mem_rd(base + 32'(2*k));
      rq.push_back(base + 32'(2*k));
    end
    rd_nw     = 2*n;
    rcv       = 0;
    rend_seen = 0;
  endtask

  initial begin
    int k0;
    int n;
    reset = 1'b1;
    xfer_baseaddr = '0; xfer_nelems = '0; xfer_writedata = '0;
    xfer_readstart = 1'b0; xfer_writestart = 1'b0;
    tick(); tick();
    // reset state
    chk("rst_read", 64'(avm_m0_read), 64'd0);
    chk("rst_write", 64'(avm_m0_write), 64'd0);
    chk("rst_address", 64'(avm_m0_address), 64'd0);
    chk("rst_writedata", 64'(avm_m0_writedata), 64'd0);
    chk("rst_busy", 64'(xfer_busy), 64'd0);
    chk("rst_err", 64'(xfer_err), 64'd0);
    chk_buf("rst_readdata", xfer_readdata, '0);
    chk("byteenable", 64'(avm_m0_byteenable), 64'h3);
    reset = 1'b0;
    tick();

    // 1: write 3 elements, no stalls
    setup_write(32'h1000, 3, 32'hA1A1_0001);
    xfer_writestart = 1'b1; k0 = cyc; tick(); xfer_writestart = 1'b0;
    wait_end(1, "t1_writeend_seen");
    chk("t1_end_latency", 64'(wend_cyc - k0), 64'd7);
    chk("t1_accepts", 64'(wr_acc_n), 64'd6);
    chk("t1_addr0", 64'(wr_log_a[0]), 64'h1000);
    chk("t1_addr5", 64'(wr_log_a[5]), 64'h100A);
    chk("t1_data1", 64'(wr_log_d[1]), 64'hA1A1);
    chk("t1_data4", 64'(wr_log_d[4]), 64'h0003);
    chk("t1_err", 64'(xfer_err), 64'd0);

    // 2: read 4 elements with 4-cycle latency against MAX_OUTSTANDING=2
    setup_read(32'h2000, 4);
    xfer_readstart = 1'b1; k0 = cyc; tick(); xfer_readstart = 1'b0;
    wait_end(0, "t2_readend_seen");
    chk("t2_end_latency", 64'(rend_cyc - k0), 64'd22);
    chk_buf("t2_readdata", xfer_readdata, exp_rd);
    chk("t2_word0", 64'(xfer_readdata[15:0]), 64'h7A5A);
    chk("t2_word7", 64'(xfer_readdata[127:112]), 64'h7A54);

    // 4: bad element counts raise err without traffic; a good start clears it
    xfer_nelems = 7'd0; wend_seen = 0; exp_wend = cyc + 1;
    xfer_writestart = 1'b1; tick(); xfer_writestart = 1'b0;
    wait_end(1, "t4_zero_end_seen");
    chk("t4_zero_err", 64'(xfer_err), 64'd1);
    xfer_nelems = 7'd65; rend_seen = 0; rd_nw = -1; exp_rend = cyc + 1;
    xfer_readstart = 1'b1; tick(); xfer_readstart = 1'b0;
    wait_end(0, "t4_over_end_seen");
    chk("t4_over_err", 64'(xfer_err), 64'd1);
    chk_buf("t4_read_accept_clears_buf", xfer_readdata, '0);
    setup_write(32'h7000, 1, 32'h1234_5678);
    xfer_writestart = 1'b1; tick(); xfer_writestart = 1'b0;
    chk("t4_err_cleared", 64'(xfer_err), 64'd0);
    chk("t4_busy_after_accept", 64'(xfer_busy), 64'd1);
    wait_end(1, "t4_good_end_seen");

    // 3: waitrequest held 5 cycles on word 2
    setup_write(32'h3000, 3, 32'h5151_1000);
    stall_word = 2; stall_left = 5; hold_n = 0;
    xfer_writestart = 1'b1; k0 = cyc; tick(); xfer_writestart = 1'b0;
    wait_end(1, "t3_writeend_seen");
    chk("t3_end_latency", 64'(wend_cyc - k0), 64'd12);
    chk("t3_hold_cycles", 64'(hold_n), 64'd5);
    chk("t3_accepts", 64'(wr_acc_n), 64'd6);
    stall_word = -1;

    // 5: both starts: write first, read re-accepted from IDLE afterwards
    setup_write(32'h4000, 1, 32'hCAFE_F00D);
    xfer_nelems = 7'd1;
    rq.push_back(32'h4000); rq.push_back(32'h4002);
    exp_rd = '0; exp_rd[31:0] = 32'hCAFE_F00D;
    rd_nw = 2; rcv = 0; rend_seen = 0; rd_first = -1;
    xfer_writestart = 1'b1; xfer_readstart = 1'b1; k0 = cyc; tick(); xfer_writestart = 1'b0;
    wait_end(1, "t5_writeend_seen");
    n = 0;
    while (rd_first < 0 && n < 50) begin tick(); n++; end
    xfer_readstart = 1'b0;
    wait_end(0, "t5_readend_seen");
    chk("t5_write_latency", 64'(wend_cyc - k0), 64'd3);
    chk("t5_read_gap", 64'(rd_first - wend_cyc), 64'd2);
    chk("t5_readback", 64'(xfer_readdata[31:0]), 64'hCAFE_F00D);
    chk_buf("t5_readdata", xfer_readdata, exp_rd);

    // 6: reset in the middle of a read, late responses must be ignored
    setup_read(32'h5000, 8);
    xfer_readstart = 1'b1; tick(); xfer_readstart = 1'b0;
    n = 0;
    while (out_cnt < MO && n < 50) begin tick(); n++; end
    chk("t6_reached_outstanding", 64'(out_cnt), 64'(MO));
    reset = 1'b1;
    cur_tag++; out_cnt = 0; rq.delete(); exp_rend = -1; rd_nw = -1;
    #1;
    chk("t6_rst_read", 64'(avm_m0_read), 64'd0);
    chk("t6_rst_address", 64'(avm_m0_address), 64'd0);
    chk("t6_rst_busy", 64'(xfer_busy), 64'd0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_buf("t6_late_rdv_ignored", xfer_readdata, '0);
    setup_read(32'h6000, 2);
    xfer_readstart = 1'b1; tick(); xfer_readstart = 1'b0;
    wait_end(0, "t6_new_readend_seen");
    chk_buf("t6_new_readdata", xfer_readdata, exp_rd);
    chk("t6_new_word0", 64'(xfer_readdata[15:0]), 64'h3A5A);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

endmodule
